regdump_uart_tx: RTL and testbench

- Hardware-side counterpart of the processor testbench's register check.
- On program halt (`jal x0,0` held in the instruction stream) or on an explicit start pulse, it reads x0..x31 through a register-file read port.
- It transmits each value over UART 8N1 as 8 lowercase hex ASCII digits plus LF. The resulting stream matches the format of `program/expected/*.mem` and can be diffed on a board with no simulator.
- Sits in `top` beside the register file, driving the spare UART pin.

---
 rtl/regdump_pkg.sv | 34 +++
 rtl/uart_tx_byte.sv | 70 +++++++
 rtl/regdump_uart_tx.sv | 165 ++++++++++++++++
 tb/tb_regdump_uart_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regdump_pkg.sv
// regdump_pkg: shared types, constants and helpers for the register-dump UART.
//   state_t         - dump FSM states
//   tx_req_t        - byte request from the dump FSM to the byte transmitter
//   HALT_INSTR      - `jal x0,0` encoding, the self-loop a finished program sits in
//   ASCII_*         - characters used in the dump text
//   nibble_to_ascii - 4-bit value -> lowercase hex ASCII digit
package regdump_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      SEND,
      NEXT,
      FINISH
   } state_t;

   typedef struct packed {
      logic       load;
      logic [7:0] data;
   } tx_req_t;

   localparam logic [31:0] HALT_INSTR = 32'h0000_006F;
   localparam logic [7:0]  ASCII_0    = 8'h30;
   localparam logic [7:0]  ASCII_A_LC = 8'h61;
   localparam logic [7:0]  ASCII_LF   = 8'h0A;

   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
      logic [7:0] c;
      if (n < 4'd10) c = ASCII_0 + {4'h0, n};
      else           c = ASCII_A_LC + {4'h0, n} - 8'd10;
      return c;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: one-byte UART 8N1 transmitter.
//   clk       - system clock, rising edge
//   reset     - asynchronous, active-low
//   load      - accept data when ready is high
//   data      - byte to send, LSB first
//   tx        - serial line, idle high
//   byte_done - one-cycle pulse announcing the end of the stop bit
//   ready     - high when no byte is in flight
// Every bit lasts exactly CLKS_PER_BIT cycles; the counters return to zero
// at each bit and byte boundary so nothing carries into the next byte.
module uart_tx_byte #(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] data,
   output logic       tx,
   output logic       byte_done,
   output logic       ready
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   // byte_done fires one cycle ahead of the stop-bit end so that the
   // caller's one-cycle bookkeeping state overlaps the final stop cycle.
   localparam logic [BW-1:0] BAUD_DONE = BW'(CLKS_PER_BIT - 2);

   logic          active;
   logic [BW-1:0] baud_cnt;
   logic [3:0]    bit_cnt;   // 0 = start, 1..8 = data, 9 = stop
   logic [8:0]    frame;     // remaining data bits followed by the stop bit
   logic          bit_end;

   assign bit_end   = (baud_cnt == BAUD_LAST);
   assign ready     = !active;
   assign byte_done = active && (bit_cnt == 4'd9) && (baud_cnt == BAUD_DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         active   <= 1'b0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         frame    <= '1;
         tx       <= 1'b1;
      end else if (!active) begin
         if (load) begin
            active   <= 1'b1;
            tx       <= 1'b0;
            frame    <= {1'b1, data};
            baud_cnt <= '0;
            bit_cnt  <= '0;
         end
      end else if (bit_end) begin
         baud_cnt <= '0;
         if (bit_cnt == 4'd9) begin
            active  <= 1'b0;
            bit_cnt <= '0;
            tx      <= 1'b1;
         end else begin
            bit_cnt <= bit_cnt + 4'd1;
            tx      <= frame[0];
            frame   <= {1'b1, frame[8:1]};
         end
      end else begin
         baud_cnt <= baud_cnt + BW'(1);
      end
   end

endmodule

// File: rtl/regdump_uart_tx.sv
// regdump_uart_tx: dumps x0..x31 over UART as "%08x\n" lines, the same text
// as program/expected/*.mem, so a board run can be diffed without a simulator.
//   clk     - system clock, rising edge
//   reset   - asynchronous, active-low
//   start   - one-cycle dump request, dropped while busy
//   instr   - current fetched instruction, watched for the halt self-loop
//   rd_addr - register-file read address
//   rd_data - combinational register-file read data for rd_addr
//   tx      - UART serial out, idle high
//   busy    - dump in progress
//   done    - a dump completed; cleared by the next trigger
module regdump_uart_tx
   import regdump_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104,
   parameter int HALT_HOLD    = 4,
   parameter bit AUTO_EN      = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] instr,
   output logic [4:0]  rd_addr,
   input  logic [31:0] rd_data,
   output logic        tx,
   output logic        busy,
   output logic        done
);

   localparam int HW = $clog2(HALT_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HALT_HOLD);
   localparam logic [HW-1:0] HOLD_ARM = HW'(HALT_HOLD - 1);

   // ---------------- halt detection ----------------
   logic [HW-1:0] hcnt;
   logic          armed;
   logic          is_halt;
   logic          auto_trig;
   logic          trigger;

   assign is_halt   = (instr == HALT_INSTR);
   assign auto_trig = AUTO_EN && armed && (hcnt == HOLD_ARM) && is_halt;

   // armed drops on an auto trigger and only comes back once the core has
   // left the halt loop, so a single halt episode yields a single dump.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hcnt  <= '0;
         armed <= 1'b1;
      end else begin
         if (!is_halt)              hcnt <= '0;
         else if (hcnt != HOLD_MAX) hcnt <= hcnt + HW'(1);
         if (auto_trig)     armed <= 1'b0;
         else if (!is_halt) armed <= 1'b1;
      end
   end

   // ---------------- dump FSM ----------------
   state_t      state_q, state_d;
   logic [4:0]  rd_addr_q, rd_addr_d;
   logic [31:0] word_q, word_d;
   logic [2:0]  nib_q, nib_d;
   logic        lf_q, lf_d;       // the byte in SEND is the line feed
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [3:0]  cur_nib;
   tx_req_t     req;
   logic        tx_ready;
   logic        byte_done;

   assign trigger = (start || auto_trig) && (state_q == IDLE);
   assign cur_nib = word_q[{nib_q, 2'b00} +: 4];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         rd_addr_q <= '0;
         word_q    <= '0;
         nib_q     <= '0;
         lf_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_addr_q <= rd_addr_d;
         word_q    <= word_d;
         nib_q     <= nib_d;
         lf_q      <= lf_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      word_d    = word_q;
      nib_d     = nib_q;
      lf_d      = lf_q;
      busy_d    = busy_q;
      done_d    = done_q;
      req.load  = 1'b0;
      req.data  = lf_q ? ASCII_LF : nibble_to_ascii(cur_nib);
      case (state_q)
         IDLE: begin
            if (trigger) begin
               rd_addr_d = '0;
               busy_d    = 1'b1;
               done_d    = 1'b0;
               state_d   = CAPTURE;
            end
         end
         CAPTURE: begin
            word_d  = rd_data;
            nib_d   = 3'd7;
            lf_d    = 1'b0;
            state_d = SEND;
         end
         SEND: begin
            // ready is low for the whole byte, so this loads exactly once
            req.load = tx_ready;
            if (byte_done) state_d = NEXT;
         end
         NEXT: begin
            if (lf_q) begin
               if (rd_addr_q == 5'd31) begin
                  state_d = FINISH;
               end else begin
                  rd_addr_d = rd_addr_q + 5'd1;
                  state_d   = CAPTURE;
               end
            end else if (nib_q == 3'd0) begin
               lf_d    = 1'b1;
               state_d = SEND;
            end else begin
               nib_d   = nib_q - 3'd1;
               state_d = SEND;
            end
         end
         FINISH: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .clk      (clk),
      .reset    (reset),
      .load     (req.load),
      .data     (req.data),
      .tx       (tx),
      .byte_done(byte_done),
      .ready    (tx_ready)
   );

   assign rd_addr = rd_addr_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_regdump_uart_tx.sv
// tb_regdump_uart_tx: directed bench for regdump_uart_tx with CLKS_PER_BIT=4.
// A negedge UART receiver rebuilds the byte stream, which is compared against
// "%08h\n" text built from the bench's own register-file contents.
module tb_regdump_uart_tx;

   localparam int          C     = 4;
   localparam logic [31:0] HALT  = 32'h0000_006F;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam int          BUSY_CYC = 32 * (9 * (10 * C + 1) + 1) + 2;  // 11842

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [31:0] instr = NOP;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        tx, busy, done;
   logic [31:0] regs [32];

   int total = 0, passed = 0, fails = 0;

   always #5 clk = ~clk;

   assign rd_data = regs[rd_addr];

   regdump_uart_tx #(
      .CLKS_PER_BIT(C),
      .HALT_HOLD   (4),
      .AUTO_EN     (1'b1)
   ) dut (
      .clk    (clk),
      .reset  (rst_n),
      .start  (start),
      .instr  (instr),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .tx     (tx),
      .busy   (busy),
      .done   (done)
   );

   // ---------------- UART receiver (mid-bit sampling) ----------------
   logic [7:0] rx_q [$];
   logic       dec_act = 1'b0;
   int         dec_off = 0;
   logic [7:0] dec_sh = '0;
   int         frame_err = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         dec_act <= 1'b0;
      end else if (!dec_act) begin
         if (tx === 1'b0) begin
            dec_act <= 1'b1;
            dec_off <= 1;
         end
      end else begin
         dec_off <= dec_off + 1;
         if (dec_off == C / 2 && tx !== 1'b0) frame_err <= frame_err + 1;
         if (dec_off >= C + C / 2 && dec_off <= 8 * C + C / 2 && (dec_off - C / 2) % C == 0)
            dec_sh <= {tx, dec_sh[7:1]};
         if (dec_off == 9 * C + C / 2) begin
            if (tx !== 1'b1) frame_err <= frame_err + 1;
            rx_q.push_back(dec_sh);
            dec_act <= 1'b0;
         end
      end
   end

   int rx_base = 0;

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag, output int n);
      n = 0;
      while (busy === 1'b1 && n < 20000) begin
         tick();
         n++;
      end
      chk({tag, "_timeout"}, (n < 20000) ? 1 : 0, 1);
   endtask

   function automatic logic [7:0] rx_at(input int i);
      logic [7:0] b;
      b = 8'hxx;
      if (rx_base + i < rx_q.size()) b = rx_q[rx_base + i];
      return b;
   endfunction

   task automatic check_stream(input string tag);
      string exp_s;
      int    bad;
      exp_s = "";
      bad   = 0;
      for (int r = 0; r < 32; r++) exp_s = {exp_s, $sformatf("%08h\n", regs[r])};
      chk({tag, "_byte_count"}, rx_q.size() - rx_base, 288);
      for (int i = 0; i < 288; i++)
         if (rx_at(i) !== exp_s[i]) bad++;
      chk({tag, "_content_errs"}, bad, 0);
      chk({tag, "_framing_errs"}, frame_err, 0);
      rx_base = rx_q.size();
   endtask

   task automatic watch_quiet(input string tag, input int cycles);
      logic saw;
      saw = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (busy !== 1'b0 || tx !== 1'b1) saw = 1'b1;
      end
      chk(tag, saw, 1'b0);
   endtask

   initial begin
      #(3_000_000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      logic found;
      for (int r = 0; r < 32; r++) regs[r] = 32'h0;
      regs[1] = 32'h0000_000A;
      regs[2] = 32'hDEAD_BEEF;

      // reset state
      #1 rst_n = 1'b0;
      #1;
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_rd_addr", rd_addr, 5'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // A: start pulse, full dump
      @(negedge clk);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("a_busy_set", busy, 1'b1);
      chk("a_tx_capture", tx, 1'b1);
      tick();
      chk("a_tx_load_cycle", tx, 1'b1);
      tick();
      chk("a_first_start_bit", tx, 1'b0);
      wait_idle("a", n);
      chk("a_busy_cycles", 3 + n, BUSY_CYC);
      chk("a_done", done, 1'b1);
      chk("a_tx_idle", tx, 1'b1);
      chk("a_x1_digit_a", rx_at(16), 8'h61);
      chk("a_x2_digit_d", rx_at(18), 8'h64);
      chk("a_x2_digit_f", rx_at(25), 8'h66);
      chk("a_x2_lf", rx_at(26), 8'h0A);
      check_stream("a");

      // B: halt seen only 3 cycles -> no trigger
      @(negedge clk);
      instr = HALT;
      repeat (3) @(negedge clk);
      instr = NOP;
      watch_quiet("b_no_trigger", 12);
      chk("b_done_kept", done, 1'b1);

      // C: held halt triggers on its 4th cycle; start mid-dump is dropped
      @(negedge clk);
      instr = HALT;
      repeat (3) tick();
      chk("c_no_trig_cycle3", busy, 1'b0);
      tick();
      chk("c_trig_cycle4", busy, 1'b1);
      chk("c_done_clr", done, 1'b0);
      repeat (9) tick();
      @(negedge clk);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_idle("c", n);
      chk("c_busy_cycles", 11 + n, BUSY_CYC);
      check_stream("c");
      watch_quiet("c_hold_no_redump", 30);

      // D: leave and re-enter halt -> second dump; reset it mid-byte
      @(negedge clk);
      instr = NOP;
      @(negedge clk);
      instr = HALT;
      repeat (3) tick();
      chk("d_no_trig_cycle3", busy, 1'b0);
      tick();
      chk("d_retrigger", busy, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 10000 && !found; i++) begin
         tick();
         if (rd_addr == 5'd5) found = 1'b1;
      end
      chk("d_reach_x5", found, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (tx === 1'b0) found = 1'b1;
      end
      chk("d_x5_start_bit", found, 1'b1);
      repeat (4 * C + 1) @(negedge clk);
      chk("d_bit3_low", tx, 1'b0);           // '0' = 0x30, bit 3 is 0
      #2;
      rst_n = 1'b0;
      instr = NOP;
      #1;
      chk("d_rst_tx", tx, 1'b1);
      chk("d_rst_busy", busy, 1'b0);
      chk("d_rst_done", done, 1'b0);
      chk("d_rst_rd_addr", rd_addr, 5'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      rx_base = rx_q.size();

      // E: fresh start after reset dumps from x0
      @(negedge clk);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("e_busy_set", busy, 1'b1);
      wait_idle("e", n);
      chk("e_busy_cycles", 1 + n, BUSY_CYC);
      chk("e_x0_first", rx_at(0), 8'h30);
      chk("e_x0_lf", rx_at(8), 8'h0A);
      check_stream("e");

      // F: start coincides with auto trigger -> one dump
      @(negedge clk);
      instr = HALT;
      repeat (3) tick();
      @(negedge clk);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("f_busy_set", busy, 1'b1);
      wait_idle("f", n);
      chk("f_busy_cycles", 1 + n, BUSY_CYC);
      check_stream("f");
      watch_quiet("f_single_dump", 30);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
